// File: rtl/stream_source.sv
// Buffer-backed strided word streamer feeding a valid/ready channel.
// Optional STREAM_SOURCE_LOOP_EN adds loop/stop stream control.
module stream_source #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_waddr,
    input  logic [DATA_W-1:0] cfg_wdata,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] stride,
    input  logic [5:0]        count,
`ifdef STREAM_SOURCE_LOOP_EN
    input  logic              loop,
    input  logic              stop,
`endif
    output logic [DATA_W-1:0] io_dout,
    output logic              io_dout_v,
    input  logic              io_dout_r,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [5:0]        remain_q, remain_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_v_q, dout_v_d;
    logic              done_q, done_d;
    logic              free;
    logic [ADDR_W-1:0] rd_addr;
    logic [5:0]        rd_remain;
`ifdef STREAM_SOURCE_LOOP_EN
    logic [ADDR_W-1:0] base_q, base_d;
    logic [5:0]        count_q, count_d;
    logic              loop_q, loop_d;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        stride_d  = stride_q;
        remain_d  = remain_q;
        dout_d    = dout_q;
        dout_v_d  = dout_v_q;
        done_d    = 1'b0;
        free      = !dout_v_q || io_dout_r;
        rd_addr   = addr_q;
        rd_remain = remain_q;
`ifdef STREAM_SOURCE_LOOP_EN
        base_d  = base_q;
        count_d = count_q;
        loop_d  = loop_q;
        // A looping stream restarts seamlessly instead of draining
        if (remain_q == 6'd0 && loop_q) begin
            rd_addr   = base_q;
            rd_remain = count_q;
        end
        if (stop) begin
            rd_remain = 6'd0;
        end
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (count != 6'd0) begin
                        addr_d   = base;
                        stride_d = stride;
                        remain_d = count;
                        state_d  = S_RUN;
`ifdef STREAM_SOURCE_LOOP_EN
                        base_d  = base;
                        count_d = count;
                        loop_d  = loop;
`endif
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
`ifdef STREAM_SOURCE_LOOP_EN
                if (stop) begin
                    loop_d   = 1'b0;
                    remain_d = 6'd0;
                end
`endif
                if (free) begin
                    if (rd_remain != 6'd0) begin
                        dout_d   = mem[rd_addr];
                        dout_v_d = 1'b1;
                        addr_d   = rd_addr + stride_q;
                        remain_d = rd_remain - 6'd1;
                    end else begin
                        dout_v_d = 1'b0;
                        state_d  = S_FIN;
                        done_d   = 1'b1;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            stride_q <= '0;
            remain_q <= '0;
            dout_q   <= '0;
            dout_v_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef STREAM_SOURCE_LOOP_EN
            base_q  <= '0;
            count_q <= '0;
            loop_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            remain_q <= remain_d;
            dout_q   <= dout_d;
            dout_v_q <= dout_v_d;
            done_q   <= done_d;
`ifdef STREAM_SOURCE_LOOP_EN
            base_q  <= base_d;
            count_q <= count_d;
            loop_q  <= loop_d;
`endif
        end
    end

    // Buffer is not reset; NBA write gives read-before-write on collisions
    always_ff @(posedge clock) begin
        if (cfg_we) begin
            mem[cfg_waddr] <= cfg_wdata;
        end
    end

    assign io_dout   = dout_q;
    assign io_dout_v = dout_v_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;

endmodule
